// File: rtl/run_pkg.sv
// run_pkg: shared FSM state type and default widths for the run sequencer.
package run_pkg;
   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} run_state_e;
   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;
   localparam int CW_DEF = 16;
   localparam int MAX_CYCLES_DEF = 50000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear (priority over enable), saturating at all-ones.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o
);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + CW'(1) : cnt_q;
   always_ff @(posedge Clk)
      cnt_q <= Reset ? '0 : cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: program run controller (Start/Ack handshake, core enable/reset, data-memory arbitration).
// Optional RUN_WATCHDOG_EN ends a run after MAX_CYCLES RUN cycles with Timeout set.
module run_sequencer
   import run_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int CW         = CW_DEF,
   parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start_i,
   input  logic          Done_i,
   output logic          Ack_o,
   output logic          CoreEn_o,
   output logic          CoreRst_o,
   input  logic          HostReq_i,
   input  logic          HostWe_i,
   input  logic [AW-1:0] HostAddr_i,
   input  logic [DW-1:0] HostWData_i,
   output logic          HostGnt_o,
   input  logic          CoreMemWe_i,
   input  logic [AW-1:0] CoreAddr_i,
   input  logic [DW-1:0] CoreWData_i,
   output logic [AW-1:0] MemAddr_o,
   output logic          MemWe_o,
   output logic [DW-1:0] MemWData_o,
   input  logic [DW-1:0] MemRData_i,
   output logic [DW-1:0] RData_o,
   output logic [CW-1:0] CycleCt_o,
   output logic          Timeout_o
);
`ifdef RUN_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   run_state_e state_q;
   logic ack_q, core_en_q, core_rst_q, timeout_q;
   logic run, wd, cnt_clr;
   assign run = state_q == RUN;
   assign wd  = WD_EN && run && !Done_i && !Start_i && CycleCt_o == CW'(MAX_CYCLES - 1);
   // Any Start while not already armed re-arms, so the count is zero on ARM entry.
   assign cnt_clr = Start_i || state_q == ARM;
   sat_counter #(.CW(CW)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .clr_i (cnt_clr),
      .en_i  (run),
      .cnt_o (CycleCt_o)
   );
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         ack_q      <= 1'b0;
         core_en_q  <= 1'b0;
         core_rst_q <= 1'b1;
         timeout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (Start_i) state_q <= ARM;
            ARM: if (!Start_i) begin
               state_q    <= RUN;
               core_en_q  <= 1'b1;
               core_rst_q <= 1'b0;
            end
            RUN: if (Start_i) begin
               state_q    <= ARM;
               core_en_q  <= 1'b0;
               core_rst_q <= 1'b1;
            end else if (Done_i || wd) begin
               state_q   <= DONE;
               core_en_q <= 1'b0;
               ack_q     <= 1'b1;
               timeout_q <= wd;
            end
            DONE: if (Start_i) begin
               state_q    <= ARM;
               ack_q      <= 1'b0;
               core_rst_q <= 1'b1;
               timeout_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign Ack_o      = ack_q;
   assign CoreEn_o   = core_en_q;
   assign CoreRst_o  = core_rst_q;
   assign Timeout_o  = timeout_q;
   assign HostGnt_o  = HostReq_i && !run;
   assign MemAddr_o  = HostGnt_o ? HostAddr_i : CoreAddr_i;
   assign MemWData_o = HostGnt_o ? HostWData_i : CoreWData_i;
   assign MemWe_o    = (HostGnt_o && HostWe_i) || (run && CoreMemWe_i);
   assign RData_o    = MemRData_i;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table-driven check of run_sequencer with a small DataMem model.
module tb_run_sequencer;
   logic Clk = 1'b0, Reset = 1'b1;
   logic start = 0, done = 0, hreq = 0, hwe = 0, cwe = 0;
   logic [7:0] haddr = 0, hwdata = 0, caddr = 0, cwdata = 0;
   logic ack, cen, crst, gnt, mwe, tmo;
   logic [7:0] maddr, mwdata, mrdata, rdata;
   logic [3:0] cct;
   logic [7:0] mem [256];
   int n_cmp = 0, n_err = 0;
   always #5 Clk = ~Clk;
   run_sequencer #(.AW(8), .DW(8), .CW(4), .MAX_CYCLES(10)) dut (
      .Clk(Clk), .Reset(Reset), .Start_i(start), .Done_i(done), .Ack_o(ack),
      .CoreEn_o(cen), .CoreRst_o(crst), .HostReq_i(hreq), .HostWe_i(hwe),
      .HostAddr_i(haddr), .HostWData_i(hwdata), .HostGnt_o(gnt),
      .CoreMemWe_i(cwe), .CoreAddr_i(caddr), .CoreWData_i(cwdata),
      .MemAddr_o(maddr), .MemWe_o(mwe), .MemWData_o(mwdata), .MemRData_i(mrdata),
      .RData_o(rdata), .CycleCt_o(cct), .Timeout_o(tmo)
   );
   always @(posedge Clk)
      if (Reset) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      else if (mwe) mem[maddr] <= mwdata;
   assign mrdata = mem[maddr];
   typedef struct {
      logic st, dn, hr, hw;
      logic [7:0] ha, hd;
      logic cw;
      logic [7:0] ca, cd;
      logic ack, en, rst, gnt, we;
      logic [7:0] ma, rd;
      logic [3:0] ct;
   } vec_t;
   vec_t v [14];
   task automatic chk(string n, int a, int e);
      n_cmp++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic cyc(int n);
      repeat (n) @(negedge Clk);
      #1;
   endtask
   initial begin
      v[0]  = '{0,0,1,0,8'h10,8'h00,0,8'h00,8'h00, 0,0,1,1,0,8'h10,8'h00,4'd0};
      v[1]  = '{1,0,0,0,8'h00,8'h00,1,8'h20,8'h77, 0,0,1,0,0,8'h20,8'h00,4'd0};
      v[2]  = '{1,0,1,1,8'h10,8'h5A,0,8'h00,8'h00, 0,0,1,1,1,8'h10,8'h00,4'd0};
      v[3]  = '{1,0,1,0,8'h10,8'h00,0,8'h00,8'h00, 0,0,1,1,0,8'h10,8'h5A,4'd0};
      v[4]  = '{0,0,0,0,8'h00,8'h00,0,8'h00,8'h00, 0,0,1,0,0,8'h00,8'h00,4'd0};
      v[5]  = '{0,0,1,0,8'h10,8'h00,1,8'h20,8'h33, 0,1,0,0,1,8'h20,8'h00,4'd0};
      v[6]  = '{0,0,1,0,8'h10,8'h00,0,8'h20,8'h00, 0,1,0,0,0,8'h20,8'h33,4'd1};
      v[7]  = '{0,0,0,0,8'h00,8'h00,0,8'h00,8'h00, 0,1,0,0,0,8'h00,8'h00,4'd2};
      v[8]  = '{0,0,0,0,8'h00,8'h00,0,8'h00,8'h00, 0,1,0,0,0,8'h00,8'h00,4'd3};
      v[9]  = '{0,0,0,0,8'h00,8'h00,0,8'h00,8'h00, 0,1,0,0,0,8'h00,8'h00,4'd4};
      v[10] = '{0,0,0,0,8'h00,8'h00,0,8'h00,8'h00, 0,1,0,0,0,8'h00,8'h00,4'd5};
      v[11] = '{0,1,1,0,8'h10,8'h00,0,8'h00,8'h00, 0,1,0,0,0,8'h00,8'h00,4'd6};
      v[12] = '{0,0,1,0,8'h10,8'h00,0,8'h00,8'h00, 1,0,0,1,0,8'h10,8'h5A,4'd7};
      v[13] = '{0,1,0,0,8'h00,8'h00,1,8'h30,8'h99, 1,0,0,0,0,8'h30,8'h00,4'd7};
      hreq = 1;
      cyc(2);
      chk("rst_ack", ack, 0); chk("rst_crst", crst, 1); chk("rst_cen", cen, 0);
      chk("rst_cct", cct, 0); chk("rst_tmo", tmo, 0); chk("rst_gnt", gnt, 1);
      Reset = 0;
      for (int i = 0; i < 14; i++) begin
         {start, done, hreq, hwe, haddr, hwdata} = {v[i].st, v[i].dn, v[i].hr, v[i].hw, v[i].ha, v[i].hd};
         {cwe, caddr, cwdata} = {v[i].cw, v[i].ca, v[i].cd};
         #1;
         chk($sformatf("v%0d_ack", i), ack, v[i].ack);
         chk($sformatf("v%0d_en", i), cen, v[i].en);
         chk($sformatf("v%0d_rst", i), crst, v[i].rst);
         chk($sformatf("v%0d_gnt", i), gnt, v[i].gnt);
         chk($sformatf("v%0d_we", i), mwe, v[i].we);
         chk($sformatf("v%0d_maddr", i), maddr, v[i].ma);
         chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
         chk($sformatf("v%0d_cct", i), cct, v[i].ct);
         chk($sformatf("v%0d_tmo", i), tmo, 0);
         @(negedge Clk);
      end
      {start, done, hreq, hwe, cwe, haddr, caddr} = '0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("hold_cct", cct, 7); chk("hold_ack", ack, 1);
      end
      start = 1; cyc(1);
      chk("rearm_ack", ack, 0); chk("rearm_rst", crst, 1); chk("rearm_cct", cct, 0);
      start = 0; cyc(1);
      chk("run2_en", cen, 1); chk("run2_cct0", cct, 0);
      cyc(3);
      chk("run2_cct3", cct, 3);
      start = 1; cyc(1);
      chk("abort_cct", cct, 0); chk("abort_en", cen, 0); chk("abort_rst", crst, 1); chk("abort_ack", ack, 0);
      start = 0; cyc(1);
      chk("run3_cct0", cct, 0); chk("run3_en", cen, 1);
      cyc(5);
      chk("run3_ack", ack, 0); chk("run3_cct5", cct, 5);
      done = 1; cyc(1);
      chk("run3_done_ack", ack, 1); chk("run3_done_cct", cct, 6);
      done = 0; start = 1; cyc(1);
      start = 0; cyc(1);
      cyc(2);
      start = 1; done = 1; cyc(1);
      chk("prio_ack", ack, 0); chk("prio_rst", crst, 1); chk("prio_cct", cct, 0);
      start = 0; done = 0; cyc(1);
      cyc(9);
      chk("wd_cct9", cct, 9); chk("wd_ack9", ack, 0);
      cyc(1);
      chk("wd_cct10", cct, 10);
`ifdef RUN_WATCHDOG_EN
      chk("wd_ack", ack, 1); chk("wd_tmo", tmo, 1); chk("wd_en", cen, 0);
      start = 1; cyc(1);
      chk("wd_rearm_tmo", tmo, 0);
      start = 0; cyc(1);
      cyc(9);
      done = 1; cyc(1);
      chk("wd_race_ack", ack, 1); chk("wd_race_tmo", tmo, 0); chk("wd_race_cct", cct, 10);
      done = 0;
`else
      chk("nowd_ack", ack, 0); chk("nowd_tmo", tmo, 0); chk("nowd_en", cen, 1);
      cyc(10);
      chk("sat_cct", cct, 15); chk("sat_en", cen, 1);
      done = 1; cyc(1);
      chk("sat_ack", ack, 1); chk("sat_hold", cct, 15); chk("sat_tmo", tmo, 0);
      done = 0;
`endif
      start = 1; cyc(1);
      start = 0; cyc(1);
      cyc(3);
      chk("mid_cct3", cct, 3);
      Reset = 1; cyc(1);
      chk("mid_rst", crst, 1); chk("mid_en", cen, 0); chk("mid_cct", cct, 0); chk("mid_ack", ack, 0);
      Reset = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
